// File: rtl/seven_segment_arbiter_if.sv
// Requester-side bus of the display arbiter: request lines, packed data words and the registered grant/display outputs.
// Signals are level-based with no handshake; the arbiter side drives grant, owner, busy, addr and done.
interface seven_segment_arbiter_if #(
   parameter int AW   = 8,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] data_in;
   logic [NREQ-1:0]    grant;
   logic [1:0]         owner;
   logic               busy;
   logic [AW-1:0]      addr;
   logic               done;

   modport master (output req, data_in, input grant, owner, busy, addr, done);
   modport slave  (input req, data_in, output grant, owner, busy, addr, done);
endinterface

// File: rtl/seven_segment_arbiter.sv
// Round-robin sharing of the two-digit display among 4 requesters; all outputs registered, grant 1 cycle after req.
// No backpressure: the owner keeps the display until it drops req, or until its hold window expires while a competitor waits.
module seven_segment_arbiter #(
   parameter int            AW         = 8,
   parameter int            NREQ       = 4,
   parameter int            PRESCALE   = 12000000,
   parameter int            HOLD_TICKS = 2,
   parameter logic [AW-1:0] IDLE_CODE  = '0
) (
   input logic                   clk,
   input logic                   reset,
   seven_segment_arbiter_if.slave bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [1:0]      owner_q, owner_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            done_q, done_d;
   logic [1:0]      rr_q, rr_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic [AW-1:0]   data_arr [NREQ];
   logic [NREQ-1:0] others;
   logic            tick;
   logic            expired;
   logic            start;
   logic [1:0]      winner;

   // First set bit at or above ptr, wrapping; lower offsets overwrite higher ones.
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      for (int i = 0; i < NREQ; i++) data_arr[i] = bus.data_in[i*AW +: AW];
   end

   assign others = bus.req & ~grant_q;
   assign tick   = (pre_q == PW'(PRESCALE - 1));
   // Look ahead by the tick in flight so the window is exactly HOLD_TICKS*PRESCALE grant cycles.
   assign expired = (hold_q == HW'(HOLD_TICKS)) ||
                    (tick && (hold_q == HW'(HOLD_TICKS - 1)));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      rr_d    = rr_q;
      pre_d   = pre_q;
      hold_d  = hold_q;
      start   = 1'b0;
      winner  = owner_q;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               start  = 1'b1;
               winner = rr_pick(bus.req, rr_q);
            end
         end
         GRANT: begin
            if (!bus.req[owner_q]) begin
               done_d = 1'b1;
               rr_d   = owner_q + 2'd1;
               if (|bus.req) begin
                  start  = 1'b1;
                  winner = rr_pick(bus.req, owner_q + 2'd1);
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
                  addr_d  = IDLE_CODE;
               end
            end else if (expired && (|others)) begin
               done_d = 1'b1;
               rr_d   = owner_q + 2'd1;
               start  = 1'b1;
               winner = rr_pick(others, owner_q + 2'd1);
            end else begin
               addr_d = data_arr[owner_q];
               pre_d  = tick ? '0 : pre_q + PW'(1);
               if (tick && (hold_q != HW'(HOLD_TICKS))) hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = GRANT;
         grant_d = NREQ'(1) << winner;
         owner_d = winner;
         busy_d  = 1'b1;
         addr_d  = data_arr[winner];
         pre_d   = '0;
         hold_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         addr_q  <= IDLE_CODE;
         done_q  <= 1'b0;
         rr_q    <= '0;
         pre_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         rr_q    <= rr_d;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
   assign bus.addr  = addr_q;
   assign bus.done  = done_q;
endmodule
